// File: rtl/dual_issue_ctrl_pkg.sv
// Shared types and opcode helpers for the dual-issue scheduler.
// Opcodes follow the RV32 base encoding; hazard codes come from the hazard unit.
package dual_issue_ctrl_pkg;

  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned OPC_W       = 7;
  localparam int unsigned REG_W       = 5;

  localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] S_TYPE = 7'b0100011;
  localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] B_TYPE = 7'b1100011;
  localparam logic [OPC_W-1:0] I_IMME = 7'b0010011;
  localparam logic [OPC_W-1:0] R_TYPE = 7'b0110011;

  typedef enum logic [3:0] {
    NONE_h  = 4'd0,
    A_STALL = 4'd1,
    B_STALL = 4'd2,
    HOLD_B  = 4'd3
  } hazard_signal_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } issue_state_t;

  function automatic logic op_supported(input logic [OPC_W-1:0] op);
    return (op == LOAD) || (op == S_TYPE) || (op == JAL) ||
           (op == B_TYPE) || (op == I_IMME) || (op == R_TYPE);
  endfunction

  function automatic logic op_uses_rs1(input logic [OPC_W-1:0] op);
    return (op == R_TYPE) || (op == S_TYPE) || (op == B_TYPE) ||
           (op == LOAD) || (op == I_IMME);
  endfunction

  function automatic logic op_uses_rs2(input logic [OPC_W-1:0] op);
    return (op == R_TYPE) || (op == S_TYPE) || (op == B_TYPE);
  endfunction

  function automatic logic op_is_mem(input logic [OPC_W-1:0] op);
    return (op == LOAD) || (op == S_TYPE);
  endfunction

endpackage

// File: rtl/dual_issue_ctrl_if.sv
// Fetch-pair, hazard, flush and issue-slot signals of the dual-issue scheduler.
interface dual_issue_ctrl_if
  import dual_issue_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) ();

  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr_a;
  logic [INSTR_W-1:0] if_instr_b;
  logic               if_ready;
  hazard_signal_t     haz_stall_a;
  hazard_signal_t     haz_stall_b;
  logic               flush;
  logic               id_valid_a;
  logic               id_valid_b;
  logic [INSTR_W-1:0] id_instr_a;
  logic [INSTR_W-1:0] id_instr_b;
  logic [PC_W-1:0]    id_pc_a;
  logic [PC_W-1:0]    id_pc_b;
  logic               hold_b;
  logic [CNT_W-1:0]   cnt_dual;
  logic [CNT_W-1:0]   cnt_single;

  modport master (
    output if_valid, if_pc, if_instr_a, if_instr_b, haz_stall_a, haz_stall_b, flush,
    input  if_ready, id_valid_a, id_valid_b, id_instr_a, id_instr_b, id_pc_a, id_pc_b,
           hold_b, cnt_dual, cnt_single
  );

  modport slave (
    input  if_valid, if_pc, if_instr_a, if_instr_b, haz_stall_a, haz_stall_b, flush,
    output if_ready, id_valid_a, id_valid_b, id_instr_a, id_instr_b, id_pc_a, id_pc_b,
           hold_b, cnt_dual, cnt_single
  );

endinterface

// File: rtl/dual_issue_ctrl_pair_check.sv
// Combinational co-issue check for an aligned fetch pair: flags pairs that must be
// split, and B slots with an opcode the scheduler does not handle.
module dual_issue_ctrl_pair_check
  import dual_issue_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic [INSTR_W-1:0] instr_a,
  input  logic [INSTR_W-1:0] instr_b,
  output logic               conflict,
  output logic               b_drop
);

  logic [OPC_W-1:0] op_a;
  logic [OPC_W-1:0] op_b;
  logic [REG_W-1:0] rd_a;
  logic [REG_W-1:0] rs1_b;
  logic [REG_W-1:0] rs2_b;
  logic             load_use;
  logic             mem_pair;
  logic             ctrl_a;
  logic             unused_bits;

  assign op_a  = instr_a[6:0];
  assign rd_a  = instr_a[11:7];
  assign op_b  = instr_b[6:0];
  assign rs1_b = instr_b[19:15];
  assign rs2_b = instr_b[24:20];

  // Fields not involved in the pairing decision.
  assign unused_bits = ^{instr_a[INSTR_W-1:12], instr_b[INSTR_W-1:25], instr_b[14:7]};

  assign load_use = (op_a == LOAD) && (rd_a != '0) &&
                    ((op_uses_rs1(op_b) && (rs1_b == rd_a)) ||
                     (op_uses_rs2(op_b) && (rs2_b == rd_a)));
  assign mem_pair = op_is_mem(op_a) && op_is_mem(op_b);
  assign ctrl_a   = (op_a == B_TYPE) || (op_a == JAL);

  // A dropped B is never held, so it cannot also be a conflict.
  assign b_drop   = !op_supported(op_b);
  assign conflict = !b_drop && (load_use || mem_pair || ctrl_a);

endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue scheduler between fetch and ID/EX: dual-issues independent pairs, splits
// conflicting pairs by holding B for one cycle, honours stalls and flushes.
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input logic              clk,
  input logic              reset,
  dual_issue_ctrl_if.slave bus
);

  issue_state_t       state_q, state_d;
  logic               valid_a_q, valid_a_d;
  logic               valid_b_q, valid_b_d;
  logic [INSTR_W-1:0] instr_a_q, instr_a_d;
  logic [INSTR_W-1:0] instr_b_q, instr_b_d;
  logic [PC_W-1:0]    pc_a_q, pc_a_d;
  logic [PC_W-1:0]    pc_b_q, pc_b_d;
  logic               hold_b_q, hold_b_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
  logic [CNT_W-1:0]   cnt_dual_q, cnt_dual_d;
  logic [CNT_W-1:0]   cnt_single_q, cnt_single_d;

  logic            stall;
  logic            conflict;
  logic            b_drop;
  logic [PC_W-1:0] pc_b_next;

  dual_issue_ctrl_pair_check #(.INSTR_W(INSTR_W)) u_pair_check (
    .instr_a  (bus.if_instr_a),
    .instr_b  (bus.if_instr_b),
    .conflict (conflict),
    .b_drop   (b_drop)
  );

  assign stall     = (bus.haz_stall_a != NONE_h) || (bus.haz_stall_b != NONE_h);
  assign pc_b_next = bus.if_pc + PC_W'(4);
  assign bus.if_ready = (state_q == RUN) && !stall && !bus.flush;

  // State, issue slots, hold register and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      valid_a_q    <= 1'b0;
      valid_b_q    <= 1'b0;
      instr_a_q    <= '0;
      instr_b_q    <= '0;
      pc_a_q       <= '0;
      pc_b_q       <= '0;
      hold_b_q     <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      cnt_dual_q   <= '0;
      cnt_single_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_a_q    <= valid_a_d;
      valid_b_q    <= valid_b_d;
      instr_a_q    <= instr_a_d;
      instr_b_q    <= instr_b_d;
      pc_a_q       <= pc_a_d;
      pc_b_q       <= pc_b_d;
      hold_b_q     <= hold_b_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      cnt_dual_q   <= cnt_dual_d;
      cnt_single_q <= cnt_single_d;
    end
  end

  // Next-state: flush beats stall beats normal issue; a stall freezes everything.
  always_comb begin
    state_d      = state_q;
    valid_a_d    = valid_a_q;
    valid_b_d    = valid_b_q;
    instr_a_d    = instr_a_q;
    instr_b_d    = instr_b_q;
    pc_a_d       = pc_a_q;
    pc_b_d       = pc_b_q;
    hold_b_d     = hold_b_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    cnt_dual_d   = cnt_dual_q;
    cnt_single_d = cnt_single_q;

    if (bus.flush) begin
      state_d      = FLUSH;
      valid_a_d    = 1'b0;
      valid_b_d    = 1'b0;
      hold_b_d     = 1'b0;
      hold_instr_d = '0;
      hold_pc_d    = '0;
    end else if (!stall) begin
      unique case (state_q)
        RUN: begin
          valid_a_d = bus.if_valid;
          valid_b_d = 1'b0;
          if (bus.if_valid) begin
            instr_a_d = bus.if_instr_a;
            pc_a_d    = bus.if_pc;
            if (conflict || b_drop) begin
              cnt_single_d = cnt_single_q + CNT_W'(1);
            end else begin
              valid_b_d  = 1'b1;
              instr_b_d  = bus.if_instr_b;
              pc_b_d     = pc_b_next;
              cnt_dual_d = cnt_dual_q + CNT_W'(1);
            end
            if (conflict) begin
              hold_instr_d = bus.if_instr_b;
              hold_pc_d    = pc_b_next;
              hold_b_d     = 1'b1;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          valid_a_d    = 1'b1;
          valid_b_d    = 1'b0;
          instr_a_d    = hold_instr_q;
          pc_a_d       = hold_pc_q;
          cnt_single_d = cnt_single_q + CNT_W'(1);
          hold_b_d     = 1'b0;
          hold_instr_d = '0;
          hold_pc_d    = '0;
          state_d      = RUN;
        end
        FLUSH: begin
          valid_a_d = 1'b0;
          valid_b_d = 1'b0;
          state_d   = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.id_valid_a = valid_a_q;
  assign bus.id_valid_b = valid_b_q;
  assign bus.id_instr_a = instr_a_q;
  assign bus.id_instr_b = instr_b_q;
  assign bus.id_pc_a    = pc_a_q;
  assign bus.id_pc_b    = pc_b_q;
  assign bus.hold_b     = hold_b_q;
  assign bus.cnt_dual   = cnt_dual_q;
  assign bus.cnt_single = cnt_single_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl (4-bit counters so wrap is reachable):
// stimulus pushes expected issue slots, a negedge monitor pops and compares.
module tb_dual_issue_ctrl;
  import dual_issue_ctrl_pkg::*;

  localparam logic [31:0] ADD_A  = 32'h003100B3; // add  x1,x2,x3
  localparam logic [31:0] ADDI_B = 32'h00128213; // addi x4,x5,1
  localparam logic [31:0] LW5    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD_U  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] LW0    = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_X0 = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] SW6    = 32'h0060A223; // sw   x6,4(x1)
  localparam logic [31:0] JAL8   = 32'h008000EF; // jal  x1,8
  localparam logic [31:0] BADOP  = 32'h0000007F; // unsupported opcode

  typedef struct {
    logic        vb;
    logic [31:0] ia;
    logic [31:0] pa;
    logic [31:0] ib;
    logic [31:0] pb;
    logic        hb;
    logic [3:0]  cd;
    logic [3:0]  cs;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  dual_issue_ctrl_if #(.PC_W(32), .INSTR_W(32), .CNT_W(4)) bus ();

  dual_issue_ctrl #(.PC_W(32), .INSTR_W(32), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push(input logic vb, input logic [31:0] ia, input logic [31:0] pa,
                      input logic [31:0] ib, input logic [31:0] pb, input logic hb,
                      input logic [3:0] cd, input logic [3:0] cs);
    exp_t e;
    e.vb = vb; e.ia = ia; e.pa = pa; e.ib = ib; e.pb = pb; e.hb = hb; e.cd = cd; e.cs = cs;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b);
    bus.if_valid   = v;
    bus.if_pc      = pc;
    bus.if_instr_a = a;
    bus.if_instr_b = b;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with slot A valid must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    logic ok;
    if (bus.id_valid_a === 1'b1) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue: got pc_a %h instr_a %h want no issue",
                 bus.id_pc_a, bus.id_instr_a);
      end else begin
        e  = sb_q.pop_front();
        ok = (bus.id_valid_b === e.vb) && (bus.id_instr_a === e.ia) &&
             (bus.id_pc_a === e.pa) && (bus.hold_b === e.hb) &&
             (bus.cnt_dual === e.cd) && (bus.cnt_single === e.cs) &&
             (!e.vb || ((bus.id_instr_b === e.ib) && (bus.id_pc_b === e.pb)));
        if (!ok) begin
          fails++;
          $display("FAIL issue@%h: got vb=%b ia=%h pa=%h ib=%h pb=%h hb=%b cd=%0d cs=%0d want vb=%b ia=%h pa=%h ib=%h pb=%h hb=%b cd=%0d cs=%0d",
                   e.pa, bus.id_valid_b, bus.id_instr_a, bus.id_pc_a, bus.id_instr_b,
                   bus.id_pc_b, bus.hold_b, bus.cnt_dual, bus.cnt_single,
                   e.vb, e.ia, e.pa, e.ib, e.pb, e.hb, e.cd, e.cs);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.haz_stall_a = NONE_h;
    bus.haz_stall_b = NONE_h;
    bus.flush       = 1'b0;
    idle();
    step();
    step();
    chk("rst_valid_a", 32'(bus.id_valid_a), 32'd0);
    chk("rst_valid_b", 32'(bus.id_valid_b), 32'd0);
    chk("rst_hold_b", 32'(bus.hold_b), 32'd0);
    chk("rst_cnt_dual", 32'(bus.cnt_dual), 32'd0);
    chk("rst_cnt_single", 32'(bus.cnt_single), 32'd0);
    #2 reset = 1'b0;
    step();

    // Independent pair dual-issues.
    drive(1'b1, 32'h100, ADD_A, ADDI_B);
    #1 chk("ready_run", 32'(bus.if_ready), 32'd1);
    push(1'b1, ADD_A, 32'h100, ADDI_B, 32'h104, 1'b0, 4'd1, 4'd0);
    step();
    idle();
    step();
    chk("bubble_valid_a", 32'(bus.id_valid_a), 32'd0);
    chk("bubble_cnt_dual", 32'(bus.cnt_dual), 32'd1);

    // Load-use pair splits; fetch keeps presenting while held.
    drive(1'b1, 32'h200, LW5, ADD_U);
    push(1'b0, LW5, 32'h200, 32'h0, 32'h0, 1'b1, 4'd1, 4'd1);
    step();
    chk("ready_hold", 32'(bus.if_ready), 32'd0);
    push(1'b0, ADD_U, 32'h204, 32'h0, 32'h0, 1'b0, 4'd1, 4'd2);
    step();
    idle();
    #1 chk("ready_after_hold", 32'(bus.if_ready), 32'd1);

    // Stall for three cycles while holding B.
    drive(1'b1, 32'h300, LW5, ADD_U);
    push(1'b0, LW5, 32'h300, 32'h0, 32'h0, 1'b1, 4'd1, 4'd3);
    step();
    idle();
    bus.haz_stall_a = A_STALL;
    #1 chk("ready_stall", 32'(bus.if_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      push(1'b0, LW5, 32'h300, 32'h0, 32'h0, 1'b1, 4'd1, 4'd3);
      step();
    end
    bus.haz_stall_a = NONE_h;
    push(1'b0, ADD_U, 32'h304, 32'h0, 32'h0, 1'b0, 4'd1, 4'd4);
    step();

    // Flush during HOLD drops held B and yields two bubbles.
    drive(1'b1, 32'h400, LW5, ADD_U);
    push(1'b0, LW5, 32'h400, 32'h0, 32'h0, 1'b1, 4'd1, 4'd5);
    step();
    idle();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b1, 32'h500, ADD_A, ADDI_B);
    #1;
    chk("flush_bubble1_a", 32'(bus.id_valid_a), 32'd0);
    chk("flush_bubble1_b", 32'(bus.id_valid_b), 32'd0);
    chk("flush_hold_b", 32'(bus.hold_b), 32'd0);
    chk("ready_flush", 32'(bus.if_ready), 32'd0);
    step();
    chk("flush_bubble2_a", 32'(bus.id_valid_a), 32'd0);
    chk("ready_after_flush", 32'(bus.if_ready), 32'd1);
    push(1'b1, ADD_A, 32'h500, ADDI_B, 32'h504, 1'b0, 4'd2, 4'd5);
    step();
    idle();

    // Unsupported B is dropped, not held.
    drive(1'b1, 32'h600, ADDI_B, BADOP);
    push(1'b0, ADDI_B, 32'h600, 32'h0, 32'h0, 1'b0, 4'd2, 4'd6);
    step();
    idle();
    #1 chk("ready_after_drop", 32'(bus.if_ready), 32'd1);

    // Jump in A makes B speculative: split.
    drive(1'b1, 32'h700, JAL8, ADDI_B);
    push(1'b0, JAL8, 32'h700, 32'h0, 32'h0, 1'b1, 4'd2, 4'd7);
    step();
    idle();
    push(1'b0, ADDI_B, 32'h704, 32'h0, 32'h0, 1'b0, 4'd2, 4'd8);
    step();

    // Load to x0 creates no dependency: dual-issue.
    drive(1'b1, 32'h780, LW0, ADD_X0);
    push(1'b1, LW0, 32'h780, ADD_X0, 32'h784, 1'b0, 4'd3, 4'd8);
    step();

    // Two memory ops share one port: split.
    drive(1'b1, 32'h7C0, LW5, SW6);
    push(1'b0, LW5, 32'h7C0, 32'h0, 32'h0, 1'b1, 4'd3, 4'd9);
    step();
    idle();
    push(1'b0, SW6, 32'h7C4, 32'h0, 32'h0, 1'b0, 4'd3, 4'd10);
    step();

    // Async reset pulse between edges while holding B.
    drive(1'b1, 32'h800, LW5, ADD_U);
    push(1'b0, LW5, 32'h800, 32'h0, 32'h0, 1'b1, 4'd3, 4'd11);
    step();
    idle();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_valid_a", 32'(bus.id_valid_a), 32'd0);
    chk("arst_hold_b", 32'(bus.hold_b), 32'd0);
    chk("arst_pc_a", bus.id_pc_a, 32'd0);
    chk("arst_cnt_dual", 32'(bus.cnt_dual), 32'd0);
    chk("arst_cnt_single", 32'(bus.cnt_single), 32'd0);
    #1 reset = 1'b0;
    step();

    // Sixteen back-to-back pairs wrap the 4-bit dual counter to zero.
    drive(1'b1, 32'h1000, ADD_A, ADDI_B);
    #1 chk("ready_after_arst", 32'(bus.if_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h1000 + 32'(8 * i), ADD_A, ADDI_B);
      push(1'b1, ADD_A, 32'h1000 + 32'(8 * i), ADDI_B, 32'h1004 + 32'(8 * i),
           1'b0, 4'(i + 1), 4'd0);
      step();
    end
    idle();
    step();
    chk("wrap_cnt_dual", 32'(bus.cnt_dual), 32'd0);

    @(negedge clk);
    #1 chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
